// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I controller and its ALU decoder.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110
  } alu_op_e;

  typedef enum logic [1:0] {
    CLS_ADD   = 2'b00,
    CLS_SUB   = 2'b01,
    CLS_RTYPE = 2'b10,
    CLS_ITYPE = 2'b11
  } alu_class_e;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_FAULT    = 4'd11
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;
  localparam logic [1:0] SRC_B_RS2    = 2'b00;
  localparam logic [1:0] SRC_B_IMM    = 2'b01;
  localparam logic [1:0] SRC_B_FOUR   = 2'b10;
  localparam logic [1:0] IMM_I        = 2'b00;
  localparam logic [1:0] IMM_S        = 2'b01;
  localparam logic [1:0] IMM_B        = 2'b10;
  localparam logic [1:0] IMM_J        = 2'b11;
  localparam logic [1:0] RES_ALUOUT   = 2'b00;
  localparam logic [1:0] RES_DATA     = 2'b01;
  localparam logic [1:0] RES_ALU      = 2'b10;

  // Per-state control word; the pc_* / ir_en bits are enables later gated by live inputs.
  typedef struct packed {
    alu_op_e    alu;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] imm;
    logic [1:0] res;
    logic       adr;
    logic       ir_en;
    logic       pc_fetch;
    logic       pc_uncond;
    logic       pc_beq;
    logic       pc_bne;
    logic       mem_write;
    logic       reg_write;
    logic       fault;
  } ctrl_t;

  function automatic ctrl_t ctrl_fetch();
    ctrl_t c;
    c           = '0;
    c.alu       = ALU_ADD;
    c.src_a     = SRC_A_PC;
    c.src_b     = SRC_B_FOUR;
    c.res       = RES_ALU;
    c.ir_en     = 1'b1;
    c.pc_fetch  = 1'b1;
    return c;
  endfunction

  function automatic logic is_wait_state(state_e s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from the current state class and instruction fields.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_class_e  alu_class,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  output alu_op_e     alu_control
);

  // Only R-type with funct7_5 set turns funct3=000 into a subtract.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_class)
      CLS_SUB: alu_control = ALU_SUB;
      CLS_RTYPE, CLS_ITYPE: begin
        case (funct3)
          3'b000: begin
            if ((alu_class == CLS_RTYPE) && funct7_5) begin
              alu_control = ALU_SUB;
            end else begin
              alu_control = ALU_ADD;
            end
          end
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM with memory handshake timeout and sticky fault.
// Optional BNE support is enabled by defining BNE_SUPPORT_EN.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero_flag,
  input  logic       mem_ready,
  output logic [2:0] alu_control,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       fault
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  ctrl_t              ctrl_q, ctrl_d;
  alu_class_e         alu_class_s;
  alu_op_e            alu_op_s;
  logic               timed_out_s;
  logic               branch_ok_s;

  // Timeout fires on the last allowed idle cycle; a ready on that cycle still wins.
  always_comb begin
    if ((TIMEOUT != 0) && (wait_cnt_q == CNT_W'(TIMEOUT - 1))) begin
      timed_out_s = 1'b1;
    end else begin
      timed_out_s = 1'b0;
    end
  end

  // Supported branch conditions.
  always_comb begin
`ifdef BNE_SUPPORT_EN
    branch_ok_s = (funct3 == 3'b000) || (funct3 == 3'b001);
`else
    branch_ok_s = (funct3 == 3'b000);
`endif
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH, S_MEMREAD, S_MEMWRITE: begin
        if (mem_ready) begin
          case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_MEMREAD: state_d = S_MEMWB;
            default:   state_d = S_FETCH;
          endcase
        end else if (timed_out_s) begin
          state_d = S_FAULT;
        end else begin
          state_d = state_q;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH:         state_d = S_BRANCH;
          default:           state_d = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_STORE) begin
          state_d = S_MEMWRITE;
        end else begin
          state_d = S_MEMREAD;
        end
      end
      S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB:              state_d = S_FETCH;
      S_BRANCH: begin
        if (branch_ok_s) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_FAULT;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  // Idle-cycle counter for the memory handshake states.
  always_comb begin
    if (state_d != state_q) begin
      wait_cnt_d = {CNT_W{1'b0}};
    end else if (is_wait_state(state_q) && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1'b1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // ALU operation class of the state being entered.
  always_comb begin
    case (state_d)
      S_EXECUTER: alu_class_s = CLS_RTYPE;
      S_EXECUTEI: alu_class_s = CLS_ITYPE;
      S_BRANCH:   alu_class_s = CLS_SUB;
      default:    alu_class_s = CLS_ADD;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_class   (alu_class_s),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .alu_control (alu_op_s)
  );

  // Control word of the next state, so the outputs come straight from flops.
  always_comb begin
    ctrl_d     = '0;
    ctrl_d.alu = alu_op_s;
    case (state_d)
      S_FETCH:  ctrl_d = ctrl_fetch();
      S_DECODE: begin
        ctrl_d.src_a = SRC_A_OLD_PC;
        ctrl_d.src_b = SRC_B_IMM;
        ctrl_d.imm   = IMM_B;
      end
      S_MEMADR: begin
        ctrl_d.src_a = SRC_A_RS1;
        ctrl_d.src_b = SRC_B_IMM;
        if (opcode == OP_STORE) begin
          ctrl_d.imm = IMM_S;
        end else begin
          ctrl_d.imm = IMM_I;
        end
      end
      S_MEMREAD: ctrl_d.adr = 1'b1;
      S_MEMWB: begin
        ctrl_d.res       = RES_DATA;
        ctrl_d.reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl_d.adr       = 1'b1;
        ctrl_d.mem_write = 1'b1;
      end
      S_EXECUTER: begin
        ctrl_d.src_a = SRC_A_RS1;
        ctrl_d.src_b = SRC_B_RS2;
      end
      S_EXECUTEI: begin
        ctrl_d.src_a = SRC_A_RS1;
        ctrl_d.src_b = SRC_B_IMM;
        ctrl_d.imm   = IMM_I;
      end
      S_ALUWB: begin
        ctrl_d.res       = RES_ALUOUT;
        ctrl_d.reg_write = 1'b1;
      end
      S_JAL: begin
        ctrl_d.src_a     = SRC_A_OLD_PC;
        ctrl_d.src_b     = SRC_B_FOUR;
        ctrl_d.imm       = IMM_J;
        ctrl_d.res       = RES_ALUOUT;
        ctrl_d.pc_uncond = 1'b1;
      end
      S_BRANCH: begin
        ctrl_d.src_a  = SRC_A_RS1;
        ctrl_d.src_b  = SRC_B_RS2;
        ctrl_d.res    = RES_ALUOUT;
        ctrl_d.pc_beq = (funct3 == 3'b000);
`ifdef BNE_SUPPORT_EN
        ctrl_d.pc_bne = (funct3 == 3'b001);
`else
        ctrl_d.pc_bne = 1'b0;
`endif
      end
      S_FAULT: ctrl_d.fault = 1'b1;
      default: ctrl_d.fault = 1'b1;
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= {CNT_W{1'b0}};
      ctrl_q     <= ctrl_fetch();
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ctrl_q     <= ctrl_d;
    end
  end

  assign alu_control = ctrl_q.alu;
  assign alu_src_a   = ctrl_q.src_a;
  assign alu_src_b   = ctrl_q.src_b;
  assign imm_src     = ctrl_q.imm;
  assign result_src  = ctrl_q.res;
  assign adr_src     = ctrl_q.adr;
  // The reset gate keeps the FETCH enables from strobing while reset_n is low.
  assign pc_write    = reset_n & ((ctrl_q.pc_fetch & mem_ready) | ctrl_q.pc_uncond |
                                  (ctrl_q.pc_beq & zero_flag) | (ctrl_q.pc_bne & ~zero_flag));
  assign ir_write    = reset_n & ctrl_q.ir_en & mem_ready;
  assign mem_write   = ctrl_q.mem_write;
  assign reg_write   = ctrl_q.reg_write;
  assign fault       = ctrl_q.fault;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller against an instruction-level model.
module tb_multicycle_controller;

  localparam int TMO = 16;
`ifdef BNE_SUPPORT_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  typedef enum int {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                    P_EXECR, P_EXECI, P_ALUWB, P_JAL, P_BRANCH, P_FAULT} phase_e;
  typedef enum int {K_LOAD, K_STORE, K_R, K_I, K_JAL, K_BR, K_ILL} kind_e;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7_5 = 1'b0;
  logic       zero_flag = 1'b0;
  logic       mem_ready = 1'b0;
  logic [2:0] alu_control;
  logic [1:0] alu_src_a, alu_src_b, imm_src, result_src;
  logic       adr_src, pc_write, ir_write, mem_write, reg_write, fault;

  int n_tests = 0;
  int n_fail  = 0;
  bit faulted;

  multicycle_controller #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero_flag(zero_flag), .mem_ready(mem_ready), .alu_control(alu_control),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src), .result_src(result_src),
    .adr_src(adr_src), .pc_write(pc_write), .ir_write(ir_write), .mem_write(mem_write),
    .reg_write(reg_write), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] observed();
    return {alu_control, alu_src_a, alu_src_b, imm_src, result_src,
            adr_src, pc_write, ir_write, mem_write, reg_write, fault};
  endfunction

  // Architectural ALU function the instruction asks for.
  function automatic logic [2:0] alu_ref(input bit rtype);
    case (funct3)
      3'b000:  return (rtype && funct7_5) ? 3'b110 : 3'b010;
      3'b110:  return 3'b001;
      3'b111:  return 3'b000;
      default: return 3'b010;
    endcase
  endfunction

  function automatic bit branch_legal();
    return (funct3 == 3'b000) || (BNE_EN && (funct3 == 3'b001));
  endfunction

  function automatic logic [16:0] exp_out(input phase_e ph, input logic mr, input logic zf);
    logic [2:0] alu = 3'b010;
    logic [1:0] a = 2'b00, b = 2'b00, imm = 2'b00, res = 2'b00;
    logic adr = 1'b0, pc = 1'b0, ir = 1'b0, mw = 1'b0, rw = 1'b0, ft = 1'b0;
    case (ph)
      P_FETCH:    begin b = 2'b10; res = 2'b10; pc = mr; ir = mr; end
      P_DECODE:   begin a = 2'b01; b = 2'b01; imm = 2'b10; end
      P_MEMADR:   begin a = 2'b10; b = 2'b01; imm = (opcode == 7'b0100011) ? 2'b01 : 2'b00; end
      P_MEMREAD:  adr = 1'b1;
      P_MEMWB:    begin res = 2'b01; rw = 1'b1; end
      P_MEMWRITE: begin adr = 1'b1; mw = 1'b1; end
      P_EXECR:    begin a = 2'b10; alu = alu_ref(1'b1); end
      P_EXECI:    begin a = 2'b10; b = 2'b01; alu = alu_ref(1'b0); end
      P_ALUWB:    rw = 1'b1;
      P_JAL:      begin a = 2'b01; b = 2'b10; imm = 2'b11; pc = 1'b1; end
      P_BRANCH: begin
        a = 2'b10; alu = 3'b110;
        if (funct3 == 3'b000) pc = zf;
        else if (BNE_EN && funct3 == 3'b001) pc = ~zf;
        else pc = 1'b0;
      end
      P_FAULT:    ft = 1'b1;
      default:    ft = 1'b1;
    endcase
    return {alu, a, b, imm, res, adr, pc, ir, mw, rw, ft};
  endfunction

  // One clock cycle in a known phase: drive on the falling edge, compare 1 ns later.
  task automatic step(input phase_e ph, input logic mr, input logic zf);
    @(negedge clk);
    mem_ready = mr;
    zero_flag = zf;
    #1;
    check_eq(ph.name(), {15'd0, observed()}, {15'd0, exp_out(ph, mr, zf)});
  endtask

  task automatic step_rand(input phase_e ph);
    step(ph, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Memory handshake: d idle cycles then ready, unless the idle run reaches TMO.
  task automatic wait_phase(input phase_e ph, input int d);
    for (int i = 0; i < d && i < TMO; i++) step(ph, 1'b0, 1'($urandom_range(0, 1)));
    if (d >= TMO) faulted = 1'b1;
    else step(ph, 1'b1, 1'($urandom_range(0, 1)));
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 reset_n = 1'b1;
    mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    zero_flag = 1'b1;
    #1;
    check_eq("reset", {15'd0, observed()}, {15'd0, exp_out(P_FETCH, 1'b0, 1'b0)});
    release_reset();
  endtask

  task automatic run_instr(input kind_e k, input logic [6:0] op, input logic [2:0] f3,
                           input logic f75, input int d1, input int d2, input logic zf,
                           input int tail);
    opcode = op; funct3 = f3; funct7_5 = f75;
    faulted = 1'b0;
    wait_phase(P_FETCH, d1);
    if (!faulted) begin
      step_rand(P_DECODE);
      case (k)
        K_LOAD:  begin step_rand(P_MEMADR); wait_phase(P_MEMREAD, d2);
                       if (!faulted) step_rand(P_MEMWB); end
        K_STORE: begin step_rand(P_MEMADR); wait_phase(P_MEMWRITE, d2); end
        K_R:     begin step_rand(P_EXECR); step_rand(P_ALUWB); end
        K_I:     begin step_rand(P_EXECI); step_rand(P_ALUWB); end
        K_JAL:   begin step_rand(P_JAL); step_rand(P_ALUWB); end
        K_BR:    begin step(P_BRANCH, 1'($urandom_range(0, 1)), zf);
                       if (!branch_legal()) faulted = 1'b1; end
        default: faulted = 1'b1;
      endcase
    end
    if (faulted) begin
      for (int i = 0; i < tail; i++) step_rand(P_FAULT);
      do_reset();
    end
  endtask

  function automatic int rand_delay();
    if ($urandom_range(0, 19) == 0) return int'($urandom_range(14, 18));
    return int'($urandom_range(0, 3));
  endfunction

  function automatic logic [6:0] rand_illegal();
    logic [6:0] op;
    do op = 7'($urandom);
    while (op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
           op == 7'b0010011 || op == 7'b1101111 || op == 7'b1100011);
    return op;
  endfunction

  initial begin
    do_reset();
    // lw with one late ready on each access
    run_instr(K_LOAD, 7'b0000011, 3'b010, 1'b0, 1, 1, 1'b0, 3);
    run_instr(K_R, 7'b0110011, 3'b000, 1'b1, 0, 0, 1'b0, 3);   // sub
    run_instr(K_R, 7'b0110011, 3'b000, 1'b0, 0, 0, 1'b0, 3);   // add
    run_instr(K_R, 7'b0110011, 3'b110, 1'b0, 0, 0, 1'b0, 3);   // or
    run_instr(K_R, 7'b0110011, 3'b111, 1'b0, 0, 0, 1'b0, 3);   // and
    run_instr(K_I, 7'b0010011, 3'b000, 1'b1, 0, 0, 1'b0, 3);   // addi
    run_instr(K_BR, 7'b1100011, 3'b000, 1'b0, 0, 0, 1'b1, 3);  // beq taken
    run_instr(K_BR, 7'b1100011, 3'b000, 1'b0, 0, 0, 1'b0, 3);  // beq not taken
    run_instr(K_JAL, 7'b1101111, 3'b000, 1'b0, 2, 0, 1'b0, 3);
    run_instr(K_ILL, 7'b0000000, 3'b000, 1'b0, 0, 0, 1'b0, 20);
    run_instr(K_STORE, 7'b0100011, 3'b010, 1'b0, 0, 16, 1'b0, 4); // timeout
    run_instr(K_STORE, 7'b0100011, 3'b010, 1'b0, 0, 15, 1'b0, 4); // ready on last cycle
    run_instr(K_LOAD, 7'b0000011, 3'b010, 1'b0, 16, 0, 1'b0, 4);  // fetch timeout
    run_instr(K_BR, 7'b1100011, 3'b001, 1'b0, 0, 0, 1'b0, 4);     // bne
    run_instr(K_BR, 7'b1100011, 3'b101, 1'b0, 0, 0, 1'b1, 4);     // unsupported branch
    // Asynchronous reset in the middle of a store drops mem_write at once.
    opcode = 7'b0100011; funct3 = 3'b010;
    step(P_FETCH, 1'b1, 1'b0);
    step_rand(P_DECODE);
    step_rand(P_MEMADR);
    step(P_MEMWRITE, 1'b0, 1'b0);
    #3 reset_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check_eq("async_rst", {15'd0, observed()}, {15'd0, exp_out(P_FETCH, 1'b0, 1'b0)});
    release_reset();
    step(P_FETCH, 1'b1, 1'b0);
    step_rand(P_DECODE);
    step_rand(P_MEMADR);
    step(P_MEMWRITE, 1'b1, 1'b0);
    // Random instruction mix.
    for (int n = 0; n < 300; n++) begin
      kind_e k = kind_e'($urandom_range(0, 6));
      logic [6:0] op;
      logic [2:0] f3 = 3'($urandom);
      case (k)
        K_LOAD:  op = 7'b0000011;
        K_STORE: op = 7'b0100011;
        K_R:     op = 7'b0110011;
        K_I:     op = 7'b0010011;
        K_JAL:   op = 7'b1101111;
        K_BR:    begin op = 7'b1100011; if ($urandom_range(0, 2) != 0) f3 = 3'($urandom_range(0, 1)); end
        default: op = rand_illegal();
      endcase
      run_instr(k, op, f3, 1'($urandom_range(0, 1)), rand_delay(), rand_delay(),
                1'($urandom_range(0, 1)), int'($urandom_range(1, 4)));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
